// File: rtl/axi_port_arbiter_pkg.sv
// Shared constants, FSM encodings and payload types for the AXI port arbiter.
package axi_port_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned SIZE_W = 3;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned ID_W   = 4;

    localparam int unsigned RQ_ICACHE   = 0;
    localparam int unsigned RQ_DCACHE   = 1;
    localparam int unsigned RQ_UNCACHED = 2;
    localparam int unsigned WQ_DCACHE   = 0;
    localparam int unsigned WQ_UNCACHED = 1;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_ADDR = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_AW   = 2'd1;
    localparam logic [1:0] W_W    = 2'd2;
    localparam logic [1:0] W_B    = 2'd3;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [SIZE_W-1:0] size;
    } ax_req_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
        logic              last;
    } w_beat_t;

endpackage

// File: rtl/axi_port_arbiter_rr_picker.sv
// Round-robin picker: searches from ptr_i upward and returns the first requester,
// its index, and the pointer value that gives it lowest priority next time.
module axi_port_arbiter_rr_picker #(
    parameter int unsigned N  = 3,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic [PW-1:0] nxt_o,
    output logic          any_o
);

    int unsigned   j;
    logic [PW-1:0] jx;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        nxt_o = ptr_i;
        any_o = 1'b0;
        j     = 0;
        jx    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            j  = (32'(ptr_i) + k) % N;
            jx = PW'(j);
            if (!any_o && req_i[jx]) begin
                any_o     = 1'b1;
                gnt_o[jx] = 1'b1;
                idx_o     = jx;
                nxt_o     = (j + 1 == N) ? '0 : PW'(j + 1);
            end
        end
    end

endmodule

// File: rtl/axi_port_arbiter.sv
// Shares one AXI master port between icache, dcache and uncached requesters;
// read and write channels arbitrate independently, data-side reads wait for writes.
module axi_port_arbiter
    import axi_port_arbiter_pkg::*;
#(
    parameter int unsigned NR = 3,
    parameter int unsigned NW = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NR-1:0]        s_arvalid,
    input  logic [ADDR_W*NR-1:0] s_araddr,
    input  logic [LEN_W*NR-1:0]  s_arlen,
    input  logic [SIZE_W*NR-1:0] s_arsize,
    output logic [NR-1:0]        s_arready,
    output logic [DATA_W-1:0]    s_rdata,
    output logic                 s_rlast,
    output logic [NR-1:0]        s_rvalid,
    input  logic [NR-1:0]        s_rready,
    input  logic [NW-1:0]        s_awvalid,
    input  logic [ADDR_W*NW-1:0] s_awaddr,
    input  logic [LEN_W*NW-1:0]  s_awlen,
    input  logic [SIZE_W*NW-1:0] s_awsize,
    output logic [NW-1:0]        s_awready,
    input  logic [NW-1:0]        s_wvalid,
    input  logic [DATA_W*NW-1:0] s_wdata,
    input  logic [STRB_W*NW-1:0] s_wstrb,
    input  logic [NW-1:0]        s_wlast,
    output logic [NW-1:0]        s_wready,
    output logic [NW-1:0]        s_bvalid,
    input  logic [NW-1:0]        s_bready,
    output logic [ID_W-1:0]      m_arid,
    output logic [ADDR_W-1:0]    m_araddr,
    output logic [LEN_W-1:0]     m_arlen,
    output logic [SIZE_W-1:0]    m_arsize,
    output logic                 m_arvalid,
    input  logic                 m_arready,
    input  logic [ID_W-1:0]      m_rid,
    input  logic [DATA_W-1:0]    m_rdata,
    input  logic                 m_rlast,
    input  logic                 m_rvalid,
    output logic                 m_rready,
    output logic [ID_W-1:0]      m_awid,
    output logic [ADDR_W-1:0]    m_awaddr,
    output logic [LEN_W-1:0]     m_awlen,
    output logic [SIZE_W-1:0]    m_awsize,
    output logic                 m_awvalid,
    input  logic                 m_awready,
    output logic [DATA_W-1:0]    m_wdata,
    output logic [STRB_W-1:0]    m_wstrb,
    output logic                 m_wlast,
    output logic                 m_wvalid,
    input  logic                 m_wready,
    input  logic                 m_bvalid,
    output logic                 m_bready,
    output logic                 write_busy
);

    localparam int unsigned RPW = (NR > 1) ? $clog2(NR) : 1;
    localparam int unsigned WPW = (NW > 1) ? $clog2(NW) : 1;

    ax_req_t ar_a [NR];
    ax_req_t aw_a [NW];
    w_beat_t w_a  [NW];

    for (genvar g = 0; g < NR; g++) begin : g_ar
        assign ar_a[g] = '{addr: s_araddr[g*ADDR_W +: ADDR_W],
                           len:  s_arlen[g*LEN_W +: LEN_W],
                           size: s_arsize[g*SIZE_W +: SIZE_W]};
    end
    for (genvar g = 0; g < NW; g++) begin : g_aw
        assign aw_a[g] = '{addr: s_awaddr[g*ADDR_W +: ADDR_W],
                           len:  s_awlen[g*LEN_W +: LEN_W],
                           size: s_awsize[g*SIZE_W +: SIZE_W]};
        assign w_a[g]  = '{data: s_wdata[g*DATA_W +: DATA_W],
                           strb: s_wstrb[g*STRB_W +: STRB_W],
                           last: s_wlast[g]};
    end

    // Responses carry no routing information with one transaction outstanding.
    logic unused_rid;
    assign unused_rid = ^m_rid;

    logic [1:0]     r_state_q, r_state_d, w_state_q, w_state_d;
    logic [NR-1:0]  rgnt_q, rgnt_d, r_elig, r_pick;
    logic [RPW-1:0] ridx_q, ridx_d, rptr_q, rptr_d, r_pick_idx, r_pick_nxt;
    logic [NW-1:0]  wgnt_q, wgnt_d, w_pick;
    logic [WPW-1:0] widx_q, widx_d, wptr_q, wptr_d, w_pick_idx, w_pick_nxt;
    logic           r_any, w_any, w_idle;

    assign w_idle = (w_state_q == W_IDLE);

    // Data-side reads are held back while any write is in flight.
    always_comb begin
        r_elig              = '0;
        r_elig[RQ_ICACHE]   = 1'b1;
        r_elig[RQ_DCACHE]   = w_idle;
        r_elig[RQ_UNCACHED] = w_idle;
    end

    axi_port_arbiter_rr_picker #(.N(NR), .PW(RPW)) u_rd_pick (
        .req_i (s_arvalid & r_elig),
        .ptr_i (rptr_q),
        .gnt_o (r_pick),
        .idx_o (r_pick_idx),
        .nxt_o (r_pick_nxt),
        .any_o (r_any)
    );

    axi_port_arbiter_rr_picker #(.N(NW), .PW(WPW)) u_wr_pick (
        .req_i (s_awvalid),
        .ptr_i (wptr_q),
        .gnt_o (w_pick),
        .idx_o (w_pick_idx),
        .nxt_o (w_pick_nxt),
        .any_o (w_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            rgnt_q    <= '0;
            ridx_q    <= '0;
            rptr_q    <= '0;
            w_state_q <= W_IDLE;
            wgnt_q    <= '0;
            widx_q    <= '0;
            wptr_q    <= '0;
        end else begin
            r_state_q <= r_state_d;
            rgnt_q    <= rgnt_d;
            ridx_q    <= ridx_d;
            rptr_q    <= rptr_d;
            w_state_q <= w_state_d;
            wgnt_q    <= wgnt_d;
            widx_q    <= widx_d;
            wptr_q    <= wptr_d;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        rgnt_d    = rgnt_q;
        ridx_d    = ridx_q;
        rptr_d    = rptr_q;
        case (r_state_q)
            R_IDLE: if (r_any) begin
                rgnt_d    = r_pick;
                ridx_d    = r_pick_idx;
                rptr_d    = r_pick_nxt;
                r_state_d = R_ADDR;
            end
            R_ADDR:  if (m_arready) r_state_d = R_DATA;
            R_DATA:  if (m_rvalid && m_rready && m_rlast) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        w_state_d = w_state_q;
        wgnt_d    = wgnt_q;
        widx_d    = widx_q;
        wptr_d    = wptr_q;
        case (w_state_q)
            W_IDLE: if (w_any) begin
                wgnt_d    = w_pick;
                widx_d    = w_pick_idx;
                wptr_d    = w_pick_nxt;
                w_state_d = W_AW;
            end
            W_AW:    if (m_awready) w_state_d = W_W;
            W_W:     if (m_wvalid && m_wready && m_wlast) w_state_d = W_B;
            W_B:     if (m_bvalid && m_bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // Payloads are state-gated muxes of the granted slice; valids decode state only.
    logic r_addr, r_data, w_aw, w_w, w_b;
    assign r_addr = (r_state_q == R_ADDR);
    assign r_data = (r_state_q == R_DATA);
    assign w_aw   = (w_state_q == W_AW);
    assign w_w    = (w_state_q == W_W);
    assign w_b    = (w_state_q == W_B);

    assign m_arvalid = r_addr;
    assign m_arid    = r_addr ? ID_W'(ridx_q) : '0;
    assign m_araddr  = r_addr ? ar_a[ridx_q].addr : '0;
    assign m_arlen   = r_addr ? ar_a[ridx_q].len  : '0;
    assign m_arsize  = r_addr ? ar_a[ridx_q].size : '0;
    assign s_arready = (r_addr && m_arready) ? rgnt_q : '0;
    assign m_rready  = r_data && |(s_rready & rgnt_q);
    assign s_rvalid  = (r_data && m_rvalid) ? rgnt_q : '0;
    assign s_rdata   = r_data ? m_rdata : '0;
    assign s_rlast   = r_data && m_rlast;

    assign m_awvalid = w_aw;
    assign m_awid    = w_aw ? ID_W'(widx_q) : '0;
    assign m_awaddr  = w_aw ? aw_a[widx_q].addr : '0;
    assign m_awlen   = w_aw ? aw_a[widx_q].len  : '0;
    assign m_awsize  = w_aw ? aw_a[widx_q].size : '0;
    assign s_awready = (w_aw && m_awready) ? wgnt_q : '0;
    assign m_wvalid  = w_w && s_wvalid[widx_q];
    assign m_wdata   = w_w ? w_a[widx_q].data : '0;
    assign m_wstrb   = w_w ? w_a[widx_q].strb : '0;
    assign m_wlast   = w_w && w_a[widx_q].last;
    assign s_wready  = (w_w && m_wready) ? wgnt_q : '0;
    assign m_bready  = w_b && s_bready[widx_q];
    assign s_bvalid  = (w_b && m_bvalid) ? wgnt_q : '0;

    assign write_busy = !w_idle;

endmodule

// File: tb/tb_axi_port_arbiter.sv
// Directed bench for axi_port_arbiter: routing, round-robin order, RAW hold-off,
// concurrency, address stall and mid-transaction reset.
module tb_axi_port_arbiter;
    import axi_port_arbiter_pkg::*;

    localparam int unsigned NR = 3;
    localparam int unsigned NW = 2;

    logic clk = 1'b0;
    logic rst;
    logic [NR-1:0] s_arvalid, s_arready, s_rvalid, s_rready;
    logic [ADDR_W*NR-1:0] s_araddr;
    logic [LEN_W*NR-1:0]  s_arlen;
    logic [SIZE_W*NR-1:0] s_arsize;
    logic [DATA_W-1:0] s_rdata;
    logic s_rlast;
    logic [NW-1:0] s_awvalid, s_awready, s_wvalid, s_wlast, s_wready, s_bvalid, s_bready;
    logic [ADDR_W*NW-1:0] s_awaddr;
    logic [LEN_W*NW-1:0]  s_awlen;
    logic [SIZE_W*NW-1:0] s_awsize;
    logic [DATA_W*NW-1:0] s_wdata;
    logic [STRB_W*NW-1:0] s_wstrb;
    logic [ID_W-1:0] m_arid, m_rid, m_awid;
    logic [ADDR_W-1:0] m_araddr, m_awaddr;
    logic [LEN_W-1:0] m_arlen, m_awlen;
    logic [SIZE_W-1:0] m_arsize, m_awsize;
    logic m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
    logic m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [DATA_W-1:0] m_rdata, m_wdata;
    logic [STRB_W-1:0] m_wstrb;
    logic write_busy;

    logic [31:0] ar_addr_a [NR];
    logic [7:0]  ar_len_a  [NR];
    logic [2:0]  ar_size_a [NR];
    logic [31:0] aw_addr_a [NW];
    logic [7:0]  aw_len_a  [NW];
    logic [2:0]  aw_size_a [NW];
    logic [31:0] w_data_a  [NW];
    logic [3:0]  w_strb_a  [NW];

    for (genvar g = 0; g < NR; g++) begin : g_ar
        assign s_araddr[g*32 +: 32] = ar_addr_a[g];
        assign s_arlen[g*8 +: 8]    = ar_len_a[g];
        assign s_arsize[g*3 +: 3]   = ar_size_a[g];
    end
    for (genvar g = 0; g < NW; g++) begin : g_aw
        assign s_awaddr[g*32 +: 32] = aw_addr_a[g];
        assign s_awlen[g*8 +: 8]    = aw_len_a[g];
        assign s_awsize[g*3 +: 3]   = aw_size_a[g];
        assign s_wdata[g*32 +: 32]  = w_data_a[g];
        assign s_wstrb[g*4 +: 4]    = w_strb_a[g];
    end

    axi_port_arbiter #(.NR(NR), .NW(NW)) dut (
        .clk(clk), .rst(rst),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arready(s_arready), .s_rdata(s_rdata), .s_rlast(s_rlast), .s_rvalid(s_rvalid),
        .s_rready(s_rready),
        .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awready(s_awready), .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_wlast(s_wlast), .s_wready(s_wready), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
        .m_rready(m_rready),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
        .m_wready(m_wready), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .write_busy(write_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full read: wait for the grant, accept the address, stall one beat on a
    // non-granted ready, then stream beats; waited = cycles before m_arvalid.
    task automatic do_read(input logic [1:0] id, input logic [31:0] addr,
                           input int beats, output int waited);
        logic [2:0] oh;
        oh = 3'b001 << id;
        #1;
        waited = 0;
        while (m_arvalid !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        chk("ar_valid", 64'(m_arvalid), 64'(1));
        chk("ar_id", 64'(m_arid), 64'(id));
        chk("ar_addr", 64'(m_araddr), 64'(addr));
        m_arready = 1'b1;
        #1;
        chk("ar_ready", 64'(s_arready), 64'(oh));
        tick();
        m_arready    = 1'b0;
        s_arvalid[id] = 1'b0;
        s_rready     = ~oh;
        m_rvalid     = 1'b1;
        m_rdata      = 32'h0BAD_0BAD;
        #1;
        chk("r_ready_other", 64'(m_rready), 64'(0));
        tick();
        s_rready = oh;
        for (int b = 0; b < beats; b++) begin
            m_rdata = {addr[15:0], 16'(b)};
            m_rlast = (b == beats - 1);
            #1;
            chk("r_valid", 64'(s_rvalid), 64'(oh));
            chk("r_data", 64'(s_rdata), 64'({addr[15:0], 16'(b)}));
            chk("r_ready", 64'(m_rready), 64'(1));
            tick();
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        s_rready = '0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    int w;

    initial begin
        rst = 1'b1;
        s_arvalid = '0; s_rready = '0; s_awvalid = '0; s_wvalid = '0; s_wlast = '0;
        s_bready = '0; m_arready = 1'b0; m_rid = '0; m_rdata = '0; m_rlast = 1'b0;
        m_rvalid = 1'b0; m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
        for (int i = 0; i < int'(NR); i++) begin
            ar_addr_a[i] = '0; ar_len_a[i] = '0; ar_size_a[i] = 3'd2;
        end
        for (int i = 0; i < int'(NW); i++) begin
            aw_addr_a[i] = '0; aw_len_a[i] = '0; aw_size_a[i] = 3'd2;
            w_data_a[i] = '0; w_strb_a[i] = '0;
        end

        // Reset: requests and bus activity during reset must not leak out.
        s_arvalid = 3'b111; s_awvalid = 2'b11; s_wvalid = 2'b11;
        m_rdata = 32'hDEAD_BEEF; m_rvalid = 1'b1; m_arready = 1'b1; m_wready = 1'b1;
        ar_addr_a[0] = 32'h1234_5678; w_data_a[0] = 32'h8765_4321;
        tick(); tick();
        chk("rst_arvalid", 64'(m_arvalid), 64'(0));
        chk("rst_awvalid", 64'(m_awvalid), 64'(0));
        chk("rst_wvalid", 64'(m_wvalid), 64'(0));
        chk("rst_s_rvalid", 64'(s_rvalid), 64'(0));
        chk("rst_s_rdata", 64'(s_rdata), 64'(0));
        chk("rst_araddr", 64'(m_araddr), 64'(0));
        chk("rst_wdata", 64'(m_wdata), 64'(0));
        chk("rst_readies", 64'({s_arready, s_awready, s_wready, s_bvalid, m_rready, m_bready}), 64'(0));
        chk("rst_busy", 64'(write_busy), 64'(0));
        rst = 1'b0;
        s_arvalid = '0; s_awvalid = '0; s_wvalid = '0;
        m_rdata = '0; m_rvalid = 1'b0; m_arready = 1'b0; m_wready = 1'b0;
        tick();
        chk("idle_arvalid", 64'(m_arvalid), 64'(0));

        // Single icache refill, arlen 7, 8 beats.
        ar_addr_a[0] = 32'h1FC0_0000; ar_len_a[0] = 8'd7; s_arvalid[0] = 1'b1;
        #1;
        chk("lat_n_arvalid", 64'(m_arvalid), 64'(0));
        tick();
        chk("lat_n1_arvalid", 64'(m_arvalid), 64'(1));
        chk("ic_arlen", 64'(m_arlen), 64'(7));
        chk("ic_arsize", 64'(m_arsize), 64'(2));
        do_read(2'd0, 32'h1FC0_0000, 8, w);
        chk("ic_idle_arvalid", 64'(m_arvalid), 64'(0));
        chk("ic_idle_rvalid", 64'(s_rvalid), 64'(0));

        // Round robin from reset: all three requesters, twice.
        rst = 1'b1; tick(); rst = 1'b0;
        ar_addr_a[0] = 32'h0000_0100; ar_addr_a[1] = 32'h0000_0200; ar_addr_a[2] = 32'h0000_0300;
        ar_len_a[0] = 8'd1; ar_len_a[1] = 8'd1; ar_len_a[2] = 8'd1;
        for (int rep = 0; rep < 2; rep++) begin
            s_arvalid = 3'b111;
            for (int i = 0; i < 3; i++) begin
                do_read(2'(i), 32'h0000_0100 * (i + 1), 2, w);
                chk("rr_latency", 64'(w), 64'(1));
            end
        end

        // Uncached write then uncached read one cycle later: RAW hold-off.
        aw_addr_a[1] = 32'hBFAF_F000; aw_len_a[1] = 8'd0; w_data_a[1] = 32'h1234_5678;
        w_strb_a[1] = 4'b1111; s_wlast[1] = 1'b1; s_awvalid[1] = 1'b1; s_wvalid[1] = 1'b1;
        #1;
        chk("raw_aw_lat_n", 64'(m_awvalid), 64'(0));
        tick();
        ar_addr_a[2] = 32'hBFAF_F000; ar_len_a[2] = 8'd0; s_arvalid[2] = 1'b1;
        #1;
        chk("raw_awvalid", 64'(m_awvalid), 64'(1));
        chk("raw_awid", 64'(m_awid), 64'(WQ_UNCACHED));
        chk("raw_awaddr", 64'(m_awaddr), 64'(32'hBFAF_F000));
        chk("raw_busy", 64'(write_busy), 64'(1));
        m_awready = 1'b1;
        #1;
        chk("raw_awready", 64'(s_awready), 64'(2'b10));
        tick();
        m_awready = 1'b0; s_awvalid[1] = 1'b0;
        #1;
        chk("raw_hold_w", 64'(m_arvalid), 64'(0));
        chk("raw_wvalid", 64'(m_wvalid), 64'(1));
        chk("raw_wdata", 64'(m_wdata), 64'(32'h1234_5678));
        chk("raw_wstrb", 64'(m_wstrb), 64'(4'hF));
        chk("raw_wlast", 64'(m_wlast), 64'(1));
        m_wready = 1'b1;
        #1;
        chk("raw_wready", 64'(s_wready), 64'(2'b10));
        tick();
        m_wready = 1'b0; s_wvalid[1] = 1'b0; s_wlast[1] = 1'b0; s_bready = 2'b10;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("raw_hold_b", 64'(m_arvalid), 64'(0));
            chk("raw_bready", 64'(m_bready), 64'(1));
            chk("raw_bvalid_low", 64'(s_bvalid), 64'(0));
            tick();
        end
        m_bvalid = 1'b1;
        #1;
        chk("raw_bvalid", 64'(s_bvalid), 64'(2'b10));
        tick();
        m_bvalid = 1'b0; s_bready = '0;
        #1;
        chk("raw_busy_clear", 64'(write_busy), 64'(0));
        do_read(2'd2, 32'hBFAF_F000, 1, w);
        chk("raw_release_lat", 64'(w), 64'(1));

        // icache read during a dcache writeback of 8 beats.
        aw_addr_a[0] = 32'h0000_1000; aw_len_a[0] = 8'd7; w_strb_a[0] = 4'b1111;
        s_awvalid[0] = 1'b1; s_wvalid[0] = 1'b1;
        tick();
        chk("wb_awvalid", 64'(m_awvalid), 64'(1));
        chk("wb_awid", 64'(m_awid), 64'(WQ_DCACHE));
        chk("wb_awlen", 64'(m_awlen), 64'(7));
        m_awready = 1'b1;
        tick();
        m_awready = 1'b0; s_awvalid[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 0) begin
                ar_addr_a[0] = 32'h0000_2000; ar_len_a[0] = 8'd7; s_arvalid[0] = 1'b1;
            end
            if (k == 1) m_arready = 1'b1;
            w_data_a[0] = 32'hA000_0000 + k;
            s_wlast[0] = (k == 7);
            m_wready = 1'b1;
            #1;
            chk("wb_wvalid", 64'(m_wvalid), 64'(1));
            chk("wb_wdata", 64'(m_wdata), 64'(32'hA000_0000 + k));
            chk("wb_wready", 64'(s_wready), 64'(2'b01));
            if (k == 1) begin
                chk("cc_arvalid", 64'(m_arvalid), 64'(1));
                chk("cc_arid", 64'(m_arid), 64'(RQ_ICACHE));
                chk("cc_araddr", 64'(m_araddr), 64'(32'h0000_2000));
                chk("cc_arready", 64'(s_arready), 64'(3'b001));
            end
            tick();
            if (k == 1) begin
                m_arready = 1'b0; s_arvalid[0] = 1'b0;
            end
        end
        m_wready = 1'b0; s_wvalid[0] = 1'b0; s_wlast[0] = 1'b0;
        s_rready = 3'b001; s_bready = 2'b01;
        for (int b = 0; b < 8; b++) begin
            m_rvalid = 1'b1; m_rdata = 32'hC000_0000 + b; m_rlast = (b == 7);
            #1;
            chk("cc_rvalid", 64'(s_rvalid), 64'(3'b001));
            chk("cc_rdata", 64'(s_rdata), 64'(32'hC000_0000 + b));
            chk("cc_busy", 64'(write_busy), 64'(1));
            tick();
        end
        m_rvalid = 1'b0; m_rlast = 1'b0; s_rready = '0;
        m_bvalid = 1'b1;
        #1;
        chk("cc_bvalid", 64'(s_bvalid), 64'(2'b01));
        tick();
        m_bvalid = 1'b0; s_bready = '0;
        #1;
        chk("cc_busy_clear", 64'(write_busy), 64'(0));
        chk("cc_r_idle", 64'(m_arvalid), 64'(0));

        // Address stall: m_arready low for five cycles.
        ar_addr_a[1] = 32'h8000_0040; ar_len_a[1] = 8'd0; s_arvalid[1] = 1'b1;
        tick();
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("stall_arvalid", 64'(m_arvalid), 64'(1));
            chk("stall_araddr", 64'(m_araddr), 64'(32'h8000_0040));
            chk("stall_arready", 64'(s_arready), 64'(0));
            tick();
        end
        do_read(2'd1, 32'h8000_0040, 1, w);

        // Simultaneous read and write grants, then reset in R_DATA / W_W.
        ar_addr_a[0] = 32'h0000_3000; ar_len_a[0] = 8'd3;
        aw_addr_a[0] = 32'h0000_4000; aw_len_a[0] = 8'd3; w_data_a[0] = 32'h5555_AAAA;
        s_arvalid[0] = 1'b1; s_awvalid[0] = 1'b1; s_wvalid[0] = 1'b1;
        tick();
        chk("both_arvalid", 64'(m_arvalid), 64'(1));
        chk("both_awvalid", 64'(m_awvalid), 64'(1));
        m_arready = 1'b1; m_awready = 1'b1;
        tick();
        m_arready = 1'b0; m_awready = 1'b0; s_arvalid[0] = 1'b0; s_awvalid[0] = 1'b0;
        m_rvalid = 1'b1; m_rdata = 32'hCAFE_F00D; s_rready = 3'b001;
        #1;
        chk("pre_rst_rvalid", 64'(s_rvalid), 64'(3'b001));
        chk("pre_rst_wvalid", 64'(m_wvalid), 64'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_rvalid", 64'(s_rvalid), 64'(0));
        chk("mid_rst_rdata", 64'(s_rdata), 64'(0));
        chk("mid_rst_rready", 64'(m_rready), 64'(0));
        chk("mid_rst_wvalid", 64'(m_wvalid), 64'(0));
        chk("mid_rst_wdata", 64'(m_wdata), 64'(0));
        chk("mid_rst_busy", 64'(write_busy), 64'(0));
        chk("mid_rst_ax", 64'({m_arvalid, m_awvalid}), 64'(0));
        m_rvalid = 1'b0; m_rdata = '0; s_rready = '0; s_wvalid[0] = 1'b0;
        ar_addr_a[2] = 32'h0000_5000; ar_len_a[2] = 8'd0; s_arvalid[2] = 1'b1;
        do_read(2'd2, 32'h0000_5000, 1, w);
        chk("post_rst_lat", 64'(w), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
